// File: rtl/vga_logo_pkg.sv
// vga_logo_pkg
//   Shared constants for the animated VGA logo: default active-area and
//   logo-window sizes, the 8-entry RRGGBB palette, FSM state encodings and
//   the per-axis direction encoding.
//   Optional feature macro: VGA_LOGO_ANIM_COLOR_EN (palette colouring).
package vga_logo_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int LOGO_W_DEF   = 240;
  localparam int LOGO_H_DEF   = 240;

  typedef logic [5:0] rgb_t;

  // Entry 0 is black so a frame without any bounce leaves the reset colours
  // (black on white) in place.
  localparam logic [7:0][5:0] PALETTE = {
    6'b11_11_11,  // 7 white
    6'b00_11_11,  // 6 cyan
    6'b11_00_11,  // 5 magenta
    6'b11_11_00,  // 4 yellow
    6'b00_00_11,  // 3 blue
    6'b00_11_00,  // 2 green
    6'b11_00_00,  // 1 red
    6'b00_00_00   // 0 black
  };

  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'd0;
  localparam state_t MOVE_X  = 2'd1;
  localparam state_t MOVE_Y  = 2'd2;
  localparam state_t RECOLOR = 2'd3;

  // 0 = towards increasing coordinate (right / down), 1 = back (left / up).
  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  function automatic rgb_t pal_lookup(input logic [2:0] idx);
    return PALETTE[idx];
  endfunction

endpackage

// File: rtl/vga_logo_animator_axis_step.sv
// logo_axis_step
//   Combinational single-axis bounce step. Advances a position by step
//   pixels in its current direction, clamping at 0 or max and flipping the
//   direction when a wall is reached. Comparisons are done 11 bits wide so
//   pos+step never wraps.
//   Ports:
//     pos      in  10  current origin on this axis
//     dir      in  1   current direction (DIR_FWD / DIR_REV)
//     step     in  3   pixels per frame (1..4)
//     max      in  10  largest legal origin on this axis
//     next_pos out 10  origin after the step
//     next_dir out 1   direction after the step
//     hit      out 1   a wall was reached on this step
//   No configuration macros.
module logo_axis_step
  import vga_logo_pkg::*;
(
  input  logic [9:0] pos,
  input  logic       dir,
  input  logic [2:0] step,
  input  logic [9:0] max,
  output logic [9:0] next_pos,
  output logic       next_dir,
  output logic       hit
);

  logic [10:0] pos_w;
  logic [10:0] step_w;
  logic [10:0] max_w;
  logic [10:0] sum_w;

  always_comb begin
    pos_w    = {1'b0, pos};
    step_w   = {8'd0, step};
    max_w    = {1'b0, max};
    sum_w    = pos_w + step_w;
    next_pos = pos;
    next_dir = dir;
    hit      = 1'b0;
    if (dir == DIR_FWD) begin
      if (sum_w >= max_w) begin
        next_pos = max;
        next_dir = DIR_REV;
        hit      = 1'b1;
      end else begin
        next_pos = sum_w[9:0];
      end
    end else begin
      // Landing exactly on 0 also counts as a wall hit.
      if (pos_w <= step_w) begin
        next_pos = '0;
        next_dir = DIR_FWD;
        hit      = 1'b1;
      end else begin
        next_pos = pos - {7'd0, step};
      end
    end
  end

endmodule

// File: rtl/vga_logo_animator.sv
// vga_logo_animator
//   Per-frame motion and colour sequencer for the bouncing VGA logo. On the
//   first blank line of each frame it steps the logo origin on X, then Y,
//   then updates colours, so the visible frame never sees a partial update.
//   Also provides window-relative beam coordinates and an in-window flag.
//   Ports:
//     clk       in  1   pixel clock
//     rst_n     in  1   asynchronous active-low reset
//     hpos      in  10  beam x
//     vpos      in  10  beam y
//     run       in  1   motion enable, sampled on the frame tick
//     speed     in  2   step-1 in pixels, sampled on the frame tick
//     lx        out 10  hpos - org_x (mod 1024)
//     ly        out 10  vpos - org_y (mod 1024)
//     in_box    out 1   beam inside the logo window
//     fg        out 6   foreground RRGGBB
//     bg        out 6   background RRGGBB
//     frame_cnt out 8   frame counter
//     bounce    out 1   one-cycle pulse when a wall was hit this frame
//   Configuration macro: VGA_LOGO_ANIM_COLOR_EN -- when defined, fg/bg cycle
//   through PALETTE on every bounce; otherwise fixed black on white.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   IDLE    | waiting for the frame tick; latches run/step on it
//   MOVE_X  | steps org_x/dir_x, counts the frame
//   MOVE_Y  | steps org_y/dir_y
//   RECOLOR | advances the palette and pulses bounce on any hit
module vga_logo_animator
  import vga_logo_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int LOGO_W   = LOGO_W_DEF,
  parameter int LOGO_H   = LOGO_H_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       run,
  input  logic [1:0] speed,
  output logic [9:0] lx,
  output logic [9:0] ly,
  output logic       in_box,
  output logic [5:0] fg,
  output logic [5:0] bg,
  output logic [7:0] frame_cnt,
  output logic       bounce
);

  localparam logic [9:0]  MAX_X     = 10'(H_ACTIVE - LOGO_W);
  localparam logic [9:0]  MAX_Y     = 10'(V_ACTIVE - LOGO_H);
  localparam logic [9:0]  ORG_X_RST = 10'((H_ACTIVE - LOGO_W) / 2);
  localparam logic [9:0]  ORG_Y_RST = 10'((V_ACTIVE - LOGO_H) / 2);
  localparam logic [10:0] LOGO_W11  = 11'(LOGO_W);
  localparam logic [10:0] LOGO_H11  = 11'(LOGO_H);

  state_t     state;
  logic [9:0] org_x;
  logic [9:0] org_y;
  logic       dir_x;
  logic       dir_y;
  logic [2:0] step_q;
  logic       run_q;
  logic       hit_x;
  logic       hit_y;
  logic       tick;

  logic [9:0] ax_pos;
  logic       ax_dir;
  logic [9:0] ax_max;
  logic [9:0] ax_next_pos;
  logic       ax_next_dir;
  logic       ax_hit;

  assign tick = (hpos == 10'd0) && (vpos == 10'(V_ACTIVE));

  // One stepper serves both axes; MOVE_Y selects the Y operands.
  always_comb begin
    ax_pos = org_x;
    ax_dir = dir_x;
    ax_max = MAX_X;
    if (state == MOVE_Y) begin
      ax_pos = org_y;
      ax_dir = dir_y;
      ax_max = MAX_Y;
    end
  end

  logo_axis_step u_axis_step (
    .pos      (ax_pos),
    .dir      (ax_dir),
    .step     (step_q),
    .max      (ax_max),
    .next_pos (ax_next_pos),
    .next_dir (ax_next_dir),
    .hit      (ax_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      org_x     <= ORG_X_RST;
      org_y     <= ORG_Y_RST;
      dir_x     <= DIR_FWD;
      dir_y     <= DIR_FWD;
      step_q    <= 3'd1;
      run_q     <= 1'b0;
      hit_x     <= 1'b0;
      hit_y     <= 1'b0;
      frame_cnt <= 8'd0;
      bounce    <= 1'b0;
    end else begin
      bounce <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            step_q <= {1'b0, speed} + 3'd1;
            run_q  <= run;
            hit_x  <= 1'b0;
            hit_y  <= 1'b0;
            state  <= MOVE_X;
          end
        end
        MOVE_X: begin
          frame_cnt <= frame_cnt + 8'd1;
          if (run_q) begin
            org_x <= ax_next_pos;
            dir_x <= ax_next_dir;
            hit_x <= ax_hit;
          end
          state <= MOVE_Y;
        end
        MOVE_Y: begin
          if (run_q) begin
            org_y <= ax_next_pos;
            dir_y <= ax_next_dir;
            hit_y <= ax_hit;
          end
          state <= RECOLOR;
        end
        RECOLOR: begin
          bounce <= hit_x | hit_y;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VGA_LOGO_ANIM_COLOR_EN
  logic [2:0] pal_idx;
  logic [2:0] pal_next;
  rgb_t       fg_q;

  // A corner hit advances the palette once, not twice.
  assign pal_next = (hit_x | hit_y) ? pal_idx + 3'd1 : pal_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pal_idx <= 3'd0;
      fg_q    <= 6'b00_00_00;
    end else if (state == RECOLOR) begin
      pal_idx <= pal_next;
      fg_q    <= pal_lookup(pal_next);
    end
  end

  assign fg = fg_q;
  assign bg = ~fg_q;
`else
  assign fg = 6'b00_00_00;
  assign bg = 6'b11_11_11;
`endif

  logic [10:0] box_x_end;
  logic [10:0] box_y_end;

  assign lx        = hpos - org_x;
  assign ly        = vpos - org_y;
  assign box_x_end = {1'b0, org_x} + LOGO_W11;
  assign box_y_end = {1'b0, org_y} + LOGO_H11;
  assign in_box    = (hpos >= org_x) && ({1'b0, hpos} < box_x_end) &&
                     (vpos >= org_y) && ({1'b0, vpos} < box_y_end);

endmodule

// File: tb/tb_vga_logo_animator.sv
module tb_vga_logo_animator;

  logic       clk;
  logic       rst_n;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       run;
  logic [1:0] speed;
  logic [9:0] lx;
  logic [9:0] ly;
  logic       in_box;
  logic [5:0] fg;
  logic [5:0] bg;
  logic [7:0] frame_cnt;
  logic       bounce;

  int n_checks = 0;
  int n_pass   = 0;
  int n_bounce = 0;
  int b0;

  // Expected colours, hand-coded independently of the design package.
  logic [5:0] exp_pal [8];

  vga_logo_animator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hpos      (hpos),
    .vpos      (vpos),
    .run       (run),
    .speed     (speed),
    .lx        (lx),
    .ly        (ly),
    .in_box    (in_box),
    .fg        (fg),
    .bg        (bg),
    .frame_cnt (frame_cnt),
    .bounce    (bounce)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bounce === 1'b1) n_bounce <= n_bounce + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  // Origin as seen through lx/ly with the beam parked at (0,0).
  task automatic check_org(input string tag, input int ex, input int ey);
    check({tag, " org_x"}, 32'(10'(10'd0 - lx)), 32'(ex));
    check({tag, " org_y"}, 32'(10'(10'd0 - ly)), 32'(ey));
  endtask

  task automatic check_colors(input string tag, input int idx);
`ifdef VGA_LOGO_ANIM_COLOR_EN
    check({tag, " fg"}, 32'(fg), 32'(exp_pal[idx]));
    check({tag, " bg"}, 32'(bg), 32'(~exp_pal[idx]));
`else
    check({tag, " fg"}, 32'(fg), 32'(idx * 0));
    check({tag, " bg"}, 32'(bg), 32'd63);
`endif
  endtask

  // Frame tick for one cycle, then park the beam at (0,0) and scramble
  // run/speed to show they are only sampled on the tick. Returns at the
  // falling edge after the T+3 update, where a bounce pulse is visible.
  task automatic do_tick(input logic r, input logic [1:0] s);
    @(negedge clk);
    run = r; speed = s; hpos = 10'd0; vpos = 10'd480;
    @(negedge clk);
    hpos = 10'd0; vpos = 10'd0; run = ~r; speed = ~s;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    exp_pal[0] = 6'b00_00_00; exp_pal[1] = 6'b11_00_00;
    exp_pal[2] = 6'b00_11_00; exp_pal[3] = 6'b00_00_11;
    exp_pal[4] = 6'b11_11_00; exp_pal[5] = 6'b11_00_11;
    exp_pal[6] = 6'b00_11_11; exp_pal[7] = 6'b11_11_11;

    rst_n = 1'b0; hpos = 10'd0; vpos = 10'd0; run = 1'b0; speed = 2'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check_org("reset", 200, 120);
    check_colors("reset", 0);
    check("reset frame_cnt", 32'(frame_cnt), 0);
    check("reset bounce", 32'(bounce), 0);
    check("reset in_box at 0,0", 32'(in_box), 0);

    // Single tick, speed 0: cycle-by-cycle latency
    @(negedge clk);
    run = 1'b1; speed = 2'd0; hpos = 10'd0; vpos = 10'd480;
    @(negedge clk);
    hpos = 10'd0; vpos = 10'd0; run = 1'b0; speed = 2'd3;
    @(negedge clk);
    check_org("T+1", 201, 120);
    check("T+1 frame_cnt", 32'(frame_cnt), 1);
    @(negedge clk);
    check_org("T+2", 201, 121);
    @(negedge clk);
    check("T+3 bounce", 32'(bounce), 0);
    check_colors("T+3", 0);

    // Walk Y down to 238
    b0 = n_bounce;
    repeat (117) do_tick(1'b1, 2'd0);
    check_org("walk", 318, 238);
    check("walk frame_cnt", 32'(frame_cnt), 118);
    check("walk bounces", 32'(n_bounce - b0), 0);

    // speed 3 from 238 moving down: clamp to 240, flip, bounce
    do_tick(1'b1, 2'd3);
    check("ywall bounce", 32'(bounce), 1);
    check_org("ywall", 322, 240);
    check("ywall frame_cnt", 32'(frame_cnt), 119);
    check_colors("ywall", 1);
    @(negedge clk);
    check("ywall bounce width", 32'(bounce), 0);
    do_tick(1'b1, 2'd3);
    check_org("ywall next", 326, 236);
    check("ywall next bounce", 32'(bounce), 0);

    // Frozen for 10 frames
    b0 = n_bounce;
    repeat (10) do_tick(1'b0, 2'd3);
    check_org("frozen", 326, 236);
    check("frozen frame_cnt", 32'(frame_cnt), 130);
    check("frozen bounces", 32'(n_bounce - b0), 0);

    // Reset asserted mid-sequence at T+2
    @(negedge clk);
    run = 1'b1; speed = 2'd0; hpos = 10'd0; vpos = 10'd480;
    @(negedge clk);
    hpos = 10'd0; vpos = 10'd0;
    @(negedge clk);
    check_org("pre-reset", 327, 236);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_org("async reset", 200, 120);
    check("async reset frame_cnt", 32'(frame_cnt), 0);
    check("async reset bounce", 32'(bounce), 0);
    check_colors("async reset", 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_org("no tick after reset", 200, 120);
    check("no tick frame_cnt", 32'(frame_cnt), 0);

    // 200 frames at speed 0: Y wall on frame 120, X wall on frame 200
    b0 = n_bounce;
    repeat (200) do_tick(1'b1, 2'd0);
    check("xwall bounce", 32'(bounce), 1);
    check_org("xwall", 400, 160);
    check("xwall frame_cnt", 32'(frame_cnt), 200);
    check_colors("xwall", 2);
    do_tick(1'b1, 2'd0);
    check("200 frame bounces", 32'(n_bounce - b0), 2);
    check_org("xwall next", 399, 159);
    check("xwall next frame_cnt", 32'(frame_cnt), 201);
    check_colors("xwall next", 2);

    // Window decode around origin (399,159)
    hpos = 10'd399; vpos = 10'd159; #1;
    check("box origin in_box", 32'(in_box), 1);
    check("box origin lx", 32'(lx), 0);
    check("box origin ly", 32'(ly), 0);
    hpos = 10'd638; vpos = 10'd398; #1;
    check("box far corner in_box", 32'(in_box), 1);
    check("box far corner lx", 32'(lx), 239);
    check("box far corner ly", 32'(ly), 239);
    hpos = 10'd639; vpos = 10'd159; #1;
    check("box right edge out", 32'(in_box), 0);
    hpos = 10'd398; vpos = 10'd159; #1;
    check("box left edge out", 32'(in_box), 0);
    hpos = 10'd399; vpos = 10'd399; #1;
    check("box bottom edge out", 32'(in_box), 0);
    hpos = 10'd399; vpos = 10'd158; #1;
    check("box top edge out", 32'(in_box), 0);
    hpos = 10'd0; vpos = 10'd0; #1;
    check("lx wrap", 32'(lx), 625);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
